store_rmw_unit: RTL

Memory-write sequencer that performs the CPU's sw/sh/sb stores, the writing counterpart of the load path (MemDataReg + LoadBox). It sits between the ControlUnit/datapath and the memory `Datain`/`Wr` port. It takes a byte address from ALUOut and store data from register B. Word stores are written directly. Halfword and byte stores do a read-modify-write: read the aligned word, merge the lane, write it back, then pulse `done` so the ControlUnit can leave its store state.

---
 rtl/store_pkg.sv | 20 ++
 rtl/store_lane_merge.sv | 37 +++
 rtl/store_rmw_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// Shared types for the store read-modify-write path: store sizes and sequencer states.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } store_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } store_state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/store_lane_merge.sv
// Big-endian lane merge: inserts a byte/halfword/word of store data into a read word.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  store_size_t size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  // Byte offset 0 is the most significant lane.
  always_comb begin
    merged = rdata;
    case (size)
      SZ_WORD: merged = wdata;
      SZ_HALF: begin
        if (offset[1] == 1'b0) begin
          merged = {wdata[15:0], rdata[15:0]};
        end else begin
          merged = {rdata[31:16], wdata[15:0]};
        end
      end
      SZ_BYTE: begin
        case (offset)
          2'd0:    merged = {wdata[7:0], rdata[23:0]};
          2'd1:    merged = {rdata[31:24], wdata[7:0], rdata[15:0]};
          2'd2:    merged = {rdata[31:16], wdata[7:0], rdata[7:0]};
          2'd3:    merged = {rdata[31:8], wdata[7:0]};
          default: merged = rdata;
        endcase
      end
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store sequencer: word stores write directly, half/byte stores read, merge and write back.
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int READ_WAIT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_WAIT - 1);

  store_state_t     state_r, next_state_s;
  store_size_t      size_in_s, size_q;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      addr_q, wdata_q, merged_q, merged_s;
  logic             misalign_s, misalign_q;

  assign size_in_s = store_size_t'(size);

  store_lane_merge u_merge (
    .rdata  (mem_rdata),
    .wdata  (wdata_q),
    .size   (size_q),
    .offset (addr_q[1:0]),
    .merged (merged_s)
  );

  // Alignment check on the incoming request.
  always_comb begin
    misalign_s = 1'b0;
    case (size_in_s)
      SZ_WORD: misalign_s = (addr[1:0] != 2'b00);
      SZ_HALF: misalign_s = addr[0];
      SZ_BYTE: misalign_s = 1'b0;
      default: misalign_s = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!start) begin
          next_state_s = IDLE;
        end else if (misalign_s) begin
          next_state_s = DONE;
        end else if (size_in_s == SZ_WORD) begin
          next_state_s = WRITE;
        end else begin
          next_state_s = READ;
        end
      end
      READ: begin
        if (cnt_r == LAST_CNT) begin
          next_state_s = WRITE;
        end else begin
          next_state_s = READ;
        end
      end
      WRITE:   next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request latches, read-wait counter and merged write word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      size_q     <= SZ_WORD;
      merged_q   <= 32'h0000_0000;
      misalign_q <= 1'b0;
      cnt_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (start) begin
            addr_q     <= addr;
            wdata_q    <= wdata;
            size_q     <= size_in_s;
            merged_q   <= wdata;
            misalign_q <= misalign_s;
          end
        end
        READ: begin
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == LAST_CNT) begin
            merged_q <= merged_s;
          end
        end
        default: cnt_r <= '0;
      endcase
    end
  end

  // Output decode from state and latched registers only.
  always_comb begin
    mem_addr   = 32'h0000_0000;
    mem_wr     = 1'b0;
    mem_wdata  = 32'h0000_0000;
    busy       = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    case (state_r)
      IDLE: busy = 1'b0;
      READ: begin
        busy     = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
      end
      WRITE: begin
        busy      = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wr    = 1'b1;
        mem_wdata = merged_q;
      end
      DONE: begin
        busy       = 1'b1;
        mem_addr   = {addr_q[31:2], 2'b00};
        done       = 1'b1;
        misaligned = misalign_q;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule
